// File: rtl/haraka_sponge_pkg.sv
// -----------------------------------------------------------------------------
// haraka_sponge_pkg
// Shared types and defaults for the Haraka sponge controller.
//   sponge_state_e : controller FSM encoding
//   DEF_*          : default parameter values for the controller
//   rate_bytes()   : number of digest bytes available per rate block
//   cnt_w()        : counter width for a 0..n-1 counter (at least 1 bit)
// -----------------------------------------------------------------------------
package haraka_sponge_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PERM    = 2'd1,
        S_SQUEEZE = 2'd2,
        S_FINISH  = 2'd3
    } sponge_state_e;

    localparam int DEF_STATE_W = 512;
    localparam int DEF_RATE_W  = 256;
    localparam int DEF_ROUNDS  = 5;
    localparam int DEF_LEN_W   = 16;

    function automatic int rate_bytes(input int rate_w);
        return rate_w / 8;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/haraka_sponge_squeeze.sv
// -----------------------------------------------------------------------------
// haraka_sponge_squeeze
// Digest byte streamer. Holds the byte index within the current rate block and
// the number of digest bytes still owed, selects the outgoing byte (MSB-first)
// and produces the byte handshake signals.
//   internal_clk, reset : clock, async active-high reset
//   active              : controller is in the squeeze state
//   load / len          : latch the digest length (first block of a message)
//   clear               : end of message, zero both counters
//   rate                : current rate portion of the sponge state
//   out_byte/valid/last : byte stream towards the sink, out_ready from sink
//   fire                : byte accepted this cycle
//   last_byte           : the byte on offer is the final digest byte
//   rate_exhausted      : the byte on offer is the last byte of the rate
//   len_zero            : no digest bytes owed
// -----------------------------------------------------------------------------
module haraka_sponge_squeeze
    import haraka_sponge_pkg::*;
#(
    parameter int RATE_W = DEF_RATE_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              internal_clk,
    input  logic              reset,
    input  logic              active,
    input  logic              load,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic [RATE_W-1:0] rate,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              out_last,
    output logic              fire,
    output logic              last_byte,
    output logic              rate_exhausted,
    output logic              len_zero
);

    localparam int NB    = rate_bytes(RATE_W);
    localparam int IDX_W = cnt_w(NB);

    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [RATE_W-1:0] rate_shifted;

    // Shift the selected byte up to the top so byte 0 is the rate MSB.
    assign rate_shifted   = rate << {idx_q, 3'b000};

    assign out_valid      = active;
    assign out_byte       = active ? rate_shifted[RATE_W-1 -: 8] : 8'h00;
    assign last_byte      = (remaining_q == LEN_W'(1));
    assign out_last       = active & last_byte;
    assign fire           = active & out_ready;
    assign rate_exhausted = (idx_q == IDX_W'(NB - 1));
    assign len_zero       = (remaining_q == '0);

    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            remaining_q <= '0;
        end else if (clear) begin
            idx_q       <= '0;
            remaining_q <= '0;
        end else if (load) begin
            idx_q       <= '0;
            remaining_q <= len;
        end else if (fire) begin
            remaining_q <= remaining_q - LEN_W'(1);
            // Wrap at the end of the rate; the controller re-permutes then.
            idx_q       <= rate_exhausted ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/haraka_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// haraka_sponge_ctrl
// Parametrised Haraka sponge controller: absorbs padded rate blocks, drives an
// external combinational round function for ROUNDS cycles per permutation and
// streams an arbitrary-length digest as bytes, re-permuting between blocks.
//
// Optional build macro: HARAKA_SPONGE_ABORT_EN adds an 'abort' input that
// forces the message to end through S_FINISH.
//
// Ports:
//   internal_clk, reset         : clock, async active-high reset
//   in_block/in_last/in_valid   : padded message block from the padder
//   in_ready                    : block accepted (idle only)
//   digest_len                  : digest bytes, sampled on a message's 1st block
//   rnd_in/rnd_idx/rnd_out      : external round function interface
//   out_byte/out_valid/out_last : digest byte stream, out_ready from the sink
//   busy                        : message in progress
//   abort (macro only)          : terminate the current message
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a rate block; in_ready high
// S_PERM     | applying the round function, one round per cycle
// S_SQUEEZE  | offering digest bytes from the rate
// S_FINISH   | one cycle: clear state and message flags
// -----------------------------------------------------------------------------
module haraka_sponge_ctrl
    import haraka_sponge_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int RATE_W  = DEF_RATE_W,
    parameter int ROUNDS  = DEF_ROUNDS,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      internal_clk,
    input  logic                      reset,
`ifdef HARAKA_SPONGE_ABORT_EN
    input  logic                      abort,
`endif
    input  logic [RATE_W-1:0]         in_block,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LEN_W-1:0]          digest_len,
    output logic [STATE_W-1:0]        rnd_in,
    output logic [cnt_w(ROUNDS)-1:0]  rnd_idx,
    input  logic [STATE_W-1:0]        rnd_out,
    output logic [7:0]                out_byte,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int CAP_W = STATE_W - RATE_W;
    localparam int RND_W = cnt_w(ROUNDS);

    localparam logic [1:0] ST_IDLE    = S_IDLE;
    localparam logic [1:0] ST_PERM    = S_PERM;
    localparam logic [1:0] ST_SQUEEZE = S_SQUEEZE;
    localparam logic [1:0] ST_FINISH  = S_FINISH;

    logic [1:0]         fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [RND_W-1:0]   rnd_idx_q;
    logic               last_flag_q;
    logic               msg_active_q;

    logic absorb;
    logic abort_hit;
    logic rnd_last;
    logic sq_fire;
    logic sq_last_byte;
    logic sq_rate_exhausted;
    logic sq_len_zero;

`ifdef HARAKA_SPONGE_ABORT_EN
    // S_FINISH is excluded so a held abort cannot keep re-entering it.
    assign abort_hit = abort & (((fsm_q != ST_IDLE) && (fsm_q != ST_FINISH)) ||
                                ((fsm_q == ST_IDLE) && msg_active_q));
`else
    assign abort_hit = 1'b0;
`endif

    assign in_ready = (fsm_q == ST_IDLE);
    assign absorb   = in_valid & in_ready & ~abort_hit;
    assign rnd_last = (rnd_idx_q == RND_W'(ROUNDS - 1));
    assign rnd_in   = state_q;
    assign rnd_idx  = rnd_idx_q;
    assign busy     = msg_active_q;

    haraka_sponge_squeeze #(
        .RATE_W (RATE_W),
        .LEN_W  (LEN_W)
    ) u_squeeze (
        .internal_clk   (internal_clk),
        .reset          (reset),
        .active         (fsm_q == ST_SQUEEZE),
        .load           (absorb & ~msg_active_q),
        .clear          (fsm_q == ST_FINISH),
        .len            (digest_len),
        .rate           (state_q[STATE_W-1 -: RATE_W]),
        .out_ready      (out_ready),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .fire           (sq_fire),
        .last_byte      (sq_last_byte),
        .rate_exhausted (sq_rate_exhausted),
        .len_zero       (sq_len_zero)
    );

    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= ST_IDLE;
            state_q      <= '0;
            rnd_idx_q    <= '0;
            last_flag_q  <= 1'b0;
            msg_active_q <= 1'b0;
        end else if (abort_hit) begin
            fsm_q     <= ST_FINISH;
            rnd_idx_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (absorb) begin
                        // Block XORs into the rate only; capacity untouched.
                        state_q      <= state_q ^ {in_block, {CAP_W{1'b0}}};
                        rnd_idx_q    <= '0;
                        last_flag_q  <= in_last;
                        msg_active_q <= 1'b1;
                        fsm_q        <= ST_PERM;
                    end
                end
                ST_PERM: begin
                    state_q <= rnd_out;
                    if (rnd_last) begin
                        rnd_idx_q <= '0;
                        if (!last_flag_q) begin
                            fsm_q <= ST_IDLE;
                        end else if (sq_len_zero) begin
                            fsm_q <= ST_FINISH;
                        end else begin
                            fsm_q <= ST_SQUEEZE;
                        end
                    end else begin
                        rnd_idx_q <= rnd_idx_q + RND_W'(1);
                    end
                end
                ST_SQUEEZE: begin
                    if (sq_fire) begin
                        // Final byte wins over rate exhaustion: no extra permutation.
                        if (sq_last_byte) begin
                            fsm_q <= ST_FINISH;
                        end else if (sq_rate_exhausted) begin
                            fsm_q <= ST_PERM;
                        end
                    end
                end
                default: begin
                    state_q      <= '0;
                    msg_active_q <= 1'b0;
                    last_flag_q  <= 1'b0;
                    fsm_q        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
